// File: rtl/cpu_pkg.sv
// Shared CPU constants and the requester-side write request record.
// Provides register-file geometry (address width, register count, data width)
// and wr_req_t, the {addr, data} pair each execution unit presents to the
// register write arbiter.
package cpu_pkg;

    localparam int unsigned REG_ADDR_W = 3;
    localparam int unsigned NUM_REGS   = 8;
    localparam int unsigned DATA_W     = 8;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wr_req_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker.
// Scans the request vector starting at ptr_i and wrapping modulo NUM_REQ.
// It grants the first set bit it finds.
//   req_i  : request vector, one bit per requester
//   ptr_i  : index of the requester with top priority
//   gnt_o  : one-hot grant (all-zero when no request)
//   idx_o  : index of the granted requester (0 when no request)
//   any_o  : at least one request present
module rr_priority_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PW      = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [PW-1:0]      idx_o,
    output logic               any_o
);

    always_comb begin
        logic [PW-1:0] j;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = PW'((32'(ptr_i) + k) % NUM_REQ);
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Register-file write-port arbiter.
// Several requesters share the single register-file write path. One valid
// request is granted per cycle by rotating priority. A requester may hold
// top priority for up to MAX_BURST consecutive grants by asserting its lock
// bit. The accepted write is presented one cycle later on a registered,
// one-hot write-enable bus and a shared data bus.
//   clk_i       : clock
//   rst_i       : asynchronous active-high reset
//   stall_i     : suppresses all grants while high
//   req_valid_i : per-requester request present
//   req_lock_i  : per-requester request to keep priority after grant
//   req_addr_i  : packed destination indices, requester i at [i*ADDR_W +: ADDR_W]
//   req_data_i  : packed write data, requester i at [i*WIDTH +: WIDTH]
//   req_ready_o : one-hot combinational grant
//   reg_we_o    : registered one-hot write enable to the register instances
//   reg_d_o     : registered shared write data
//   wr_count_o  : accepted-write counter, wraps at 16 bits
module reg_write_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WIDTH     = cpu_pkg::DATA_W,
    parameter int unsigned NUM_REGS  = cpu_pkg::NUM_REGS,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned ADDR_W    = $clog2(NUM_REGS)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      stall_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ-1:0]        req_lock_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*WIDTH-1:0]  req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [NUM_REGS-1:0]       reg_we_o,
    output logic [WIDTH-1:0]          reg_d_o,
    output logic [15:0]               wr_count_o
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned BW = $clog2(MAX_BURST + 1);

    logic [PW-1:0]       ptr_q, ptr_d;
    logic [BW-1:0]       burst_q, burst_d;
    logic [NUM_REGS-1:0] we_q, we_d;
    logic [WIDTH-1:0]    d_q, d_d;
    logic [15:0]         cnt_q, cnt_d;

    logic [NUM_REQ-1:0]  req_eff;
    logic [NUM_REQ-1:0]  gnt;
    logic [PW-1:0]       win;
    logic                accept;
    logic [ADDR_W-1:0]   sel_addr;
    logic [WIDTH-1:0]    sel_data;
    logic [BW-1:0]       cur_burst;

    // Masking the requests here keeps req_ready low during reset and stall.
    assign req_eff = (rst_i || stall_i) ? '0 : req_valid_i;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_pick (
        .req_i (req_eff),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (win),
        .any_o (accept)
    );

    assign req_ready_o = gnt;
    assign sel_addr    = req_addr_i[win*ADDR_W +: ADDR_W];
    assign sel_data    = req_data_i[win*WIDTH +: WIDTH];
    // A burst count belongs to the requester holding ptr. Any other winner starts fresh.
    assign cur_burst   = (win == ptr_q) ? burst_q : '0;

    always_comb begin
        ptr_d   = ptr_q;
        burst_d = burst_q;
        we_d    = '0;
        d_d     = d_q;
        cnt_d   = cnt_q;
        if (accept) begin
            cnt_d = cnt_q + 16'd1;
            d_d   = sel_data;
            // Out-of-range targets are consumed and counted but write nothing.
            if (32'(sel_addr) < NUM_REGS) begin
                we_d = NUM_REGS'(1) << sel_addr;
            end
            if (req_lock_i[win] && (32'(cur_burst) < MAX_BURST - 1)) begin
                ptr_d   = win;
                burst_d = cur_burst + BW'(1);
            end else begin
                ptr_d   = (32'(win) == NUM_REQ - 1) ? '0 : win + PW'(1);
                burst_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q   <= '0;
            burst_q <= '0;
            we_q    <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
            we_q    <= we_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
        end
    end

    assign reg_we_o   = we_q;
    assign reg_d_o    = d_q;
    assign wr_count_o = cnt_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Testbench for reg_write_arbiter: a table of single-cycle vectors for
// round-robin and stall behaviour, followed by hand-written sequences for
// reset, lock/burst, out-of-range/wrap and reset mid-operation.
module tb_reg_write_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned NG = 8;
    localparam int unsigned MB = 4;
    localparam int unsigned AW = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           stall = 1'b0;
    logic [NR-1:0]  valid = '0;
    logic [NR-1:0]  lock = '0;
    logic [AW-1:0]  addr_a [NR];
    logic [W-1:0]   data_a [NR];
    logic [NR*AW-1:0] req_addr;
    logic [NR*W-1:0]  req_data;
    logic [NR-1:0]  ready;
    logic [NG-1:0]  reg_we;
    logic [W-1:0]   reg_d;
    logic [15:0]    wr_count;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NR; g++) begin : g_pack
        assign req_addr[g*AW +: AW] = addr_a[g];
        assign req_data[g*W +: W]   = data_a[g];
    end

    reg_write_arbiter #(
        .NUM_REQ   (NR),
        .WIDTH     (W),
        .NUM_REGS  (NG),
        .MAX_BURST (MB),
        .ADDR_W    (AW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .stall_i     (stall),
        .req_valid_i (valid),
        .req_lock_i  (lock),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
        .req_ready_o (ready),
        .reg_we_o    (reg_we),
        .reg_d_o     (reg_d),
        .wr_count_o  (wr_count)
    );

    // Behavioural register file fed by the arbiter outputs.
    logic [W-1:0] regs [NG];
    logic         model_clr = 1'b1;
    always @(posedge clk) begin
        for (int k = 0; k < NG; k++) begin
            if (model_clr) regs[k] <= '0;
            else if (reg_we[k]) regs[k] <= reg_d;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [NR-1:0] valid;
        logic          stall;
        logic [NR-1:0] ready;
        logic [NG-1:0] we;
        logic [W-1:0]  d;
        logic [15:0]   cnt;
    } vec_t;

    vec_t tbl [14];

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; valid = '0; lock = '0; stall = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [NR-1:0] lock_exp [5];
        logic [W-1:0]  prev5;

        // Round-robin with fixed addresses 1..4, then stall, then sparse requests.
        tbl[0]  = '{4'hF, 1'b0, 4'h1, 8'h02, 8'hA1, 16'd1};
        tbl[1]  = '{4'hF, 1'b0, 4'h2, 8'h04, 8'hB2, 16'd2};
        tbl[2]  = '{4'hF, 1'b0, 4'h4, 8'h08, 8'hC3, 16'd3};
        tbl[3]  = '{4'hF, 1'b0, 4'h8, 8'h10, 8'hD4, 16'd4};
        tbl[4]  = '{4'hF, 1'b0, 4'h1, 8'h02, 8'hA1, 16'd5};
        tbl[5]  = '{4'hF, 1'b1, 4'h0, 8'h00, 8'hA1, 16'd5};
        tbl[6]  = '{4'hF, 1'b1, 4'h0, 8'h00, 8'hA1, 16'd5};
        tbl[7]  = '{4'hF, 1'b1, 4'h0, 8'h00, 8'hA1, 16'd5};
        tbl[8]  = '{4'hF, 1'b0, 4'h2, 8'h04, 8'hB2, 16'd6};
        tbl[9]  = '{4'h0, 1'b0, 4'h0, 8'h00, 8'hB2, 16'd6};
        tbl[10] = '{4'h1, 1'b0, 4'h1, 8'h02, 8'hA1, 16'd7};
        tbl[11] = '{4'h8, 1'b0, 4'h8, 8'h10, 8'hD4, 16'd8};
        tbl[12] = '{4'hA, 1'b0, 4'h2, 8'h04, 8'hB2, 16'd9};
        tbl[13] = '{4'hA, 1'b0, 4'h8, 8'h10, 8'hD4, 16'd10};

        addr_a = '{4'd1, 4'd2, 4'd3, 4'd4};
        data_a = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

        // Reset with every requester valid.
        rst = 1'b1; valid = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_we", reg_we, 0);
        chk("rst_d", reg_d, 0);
        chk("rst_cnt", wr_count, 0);
        model_clr = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            valid = tbl[i].valid;
            stall = tbl[i].stall;
            #1;
            chk($sformatf("v%0d_ready", i), ready, tbl[i].ready);
            @(posedge clk); #1;
            chk($sformatf("v%0d_we", i), reg_we, tbl[i].we);
            chk($sformatf("v%0d_d", i), reg_d, tbl[i].d);
            chk($sformatf("v%0d_cnt", i), wr_count, tbl[i].cnt);
            if (i == 3) chk("reg3_q", regs[3], 8'hC3);
            @(negedge clk);
        end
        stall = 1'b0;

        // Lock: move ptr to 1, then requester 2 locked competes with requester 0.
        do_reset();
        valid = 4'h1; #1;
        chk("lk_pre_ready", ready, 4'h1);
        @(negedge clk);
        valid = 4'h5; lock = 4'h4;
        lock_exp = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h1};
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("lk%0d_ready", k), ready, lock_exp[k]);
            @(negedge clk);
        end
        chk("lk_cnt", wr_count, 16'd6);
        valid = '0; lock = '0;

        // Out-of-range address is accepted and counted, but writes nothing.
        do_reset();
        addr_a[0] = 4'd9; data_a[0] = 8'h99;
        valid = 4'h1; #1;
        chk("oor_ready", ready, 4'h1);
        @(posedge clk); #1;
        chk("oor_we", reg_we, 0);
        chk("oor_d", reg_d, 8'h99);
        chk("oor_cnt", wr_count, 16'd1);

        // Counter wrap: keep accepting until 0xFFFF, then one more.
        repeat (65534) @(posedge clk);
        #1;
        chk("cnt_ffff", wr_count, 16'hFFFF);
        @(posedge clk); #1;
        chk("cnt_wrap", wr_count, 16'h0000);

        // Reset right after an accept edge: pending write must vanish.
        do_reset();
        valid = 4'h1; #1;
        @(posedge clk); #1;
        @(negedge clk);
        addr_a[0] = 4'd5; data_a[0] = 8'h5A;
        prev5 = regs[5];
        @(posedge clk); #1;
        chk("mid_we_pre", reg_we, 8'h20);
        rst = 1'b1; #1;
        chk("mid_we", reg_we, 0);
        chk("mid_cnt", wr_count, 0);
        @(posedge clk); #1;
        chk("mid_reg5", regs[5], prev5);
        @(negedge clk);
        rst = 1'b0; valid = 4'hF; #1;
        chk("mid_ptr", ready, 4'h1);
        @(posedge clk); #1;
        chk("mid_post_we", reg_we, 8'h20);
        chk("mid_post_cnt", wr_count, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Shares the CPU register file's single write path among several requesters, such as the ALU result, load unit, PC-link and debug port. Each cycle it picks one valid request by rotating priority, with an optional bounded lock for bursts. It drives the one-hot `we` lines and the shared `d` bus of the 8-bit `register` instances through registered outputs. It sits between the execution units and the register-file instances, and is the only driver of their `we`/`d` inputs.

## Interface
- `NUM_REQ`, 4: number of requesters (2–8).
- `WIDTH`, 8: data width, equal to the register `WIDTH`.
- `NUM_REGS`, 8: registers addressed; address width is `$clog2(NUM_REGS)`.
- `MAX_BURST`, 4: maximum consecutive grants to one locked requester (≥1).
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `stall`  in  1  freezes arbitration; no grants while high.
- `req_valid`  in  NUM_REQ  request present, one bit per requester.
- `req_lock`  in  NUM_REQ  requester asks to keep top priority after its grant.
- `req_addr`  in  NUM_REQ*AW  packed destination register index; requester i in slice [i*AW +: AW].
- `req_data`  in  NUM_REQ*WIDTH  packed write data.
- `req_ready`  out  NUM_REQ  one-hot grant; combinational.
- `reg_we`  out  NUM_REGS  one-hot write enable to register instances; registered.
- `reg_d`  out  WIDTH  shared write data; registered.
- `wr_count`  out  16  total accepted writes; wraps at 0xFFFF→0x0000.

## Operation
- **Handshake:** a write is accepted on a rising edge where `req_valid[i] & req_ready[i]`. The requester must hold `addr`/`data`/`valid` stable until accepted. Dropping `valid` unaccepted is allowed.
- **Grant rule:**
  - `req_ready` is all-zero while `rst` or `stall` is high, or when no `valid` is set.
  - Otherwise exactly one bit is set: the first valid requester scanning from `ptr` upward, modulo `NUM_REQ`.
- **Pointer update on accept of i:**
  - If `req_lock[i]` and `burst_cnt < MAX_BURST-1`, then `ptr` stays i and `burst_cnt` increments.
  - Otherwise `ptr` becomes (i+1) mod `NUM_REQ` and `burst_cnt` becomes 0.
  - If no accept happens, `ptr` and `burst_cnt` hold.
- **Lock boundaries:**
  - A locked requester that drops `valid` loses priority naturally: the scan moves on, and the accept of another requester resets `burst_cnt`.
  - The lock gives top priority only; it never blocks other requesters while the locked one is idle.
- **Output register:**
  - On accept, the next-edge values are `reg_we` = one-hot(`req_addr[i]`) and `reg_d` = `req_data[i]`.
  - With no accept, `reg_we` = 0 and `reg_d` holds its last value.
  - An out-of-range address (≥`NUM_REGS`) is still accepted and counted, but `reg_we` = 0.
- `wr_count` increments by 1 per accept, including out-of-range accepts.
- **Reset:** `reg_we`=0, `reg_d`=0, `wr_count`=0, `ptr`=0, `burst_cnt`=0, `req_ready`=0.
  - Reset mid-operation discards any pending accepted write; no `we` pulse follows reset release.

## Timing
- Cycle N: valid seen and `req_ready` asserted combinationally.
- Edge N: handshake.
- Cycle N+1: `reg_we`/`reg_d` driven.
- Edge N+1: the target register captures; its `q` shows new data in cycle N+2.
- Throughput: one write per cycle. Back-to-back accepts produce back-to-back single-cycle `we` pulses.
- `stall` is sampled combinationally. With `stall` high in cycle N, there is no accept at edge N and `reg_we`=0 in N+1.
- First grant possible in the first cycle after `rst` deasserts.

## Structure
- Shared package `cpu_pkg`: `REG_ADDR_W` (=3), `NUM_REGS` (=8), `DATA_W` (=8) constants, and a `wr_req_t` struct {addr, data} used by requesters.
- One sub-module, `rr_priority_pick`:
  - Combinational.
  - Inputs: request vector and `ptr`.
  - Outputs: one-hot grant and winner index.
- Pointer, burst counter, output registers and the `wr_count` counter live in the top module.

## Test plan
- **Reset:**
  - Stimulus: `rst`=1 with all `req_valid`=1.
  - Required: `req_ready`=0, `reg_we`=0, `reg_d`=0x00, `wr_count`=0.
  - Then deassert `rst`; requester 0 is granted first.
- **Round-robin:**
  - Stimulus: all four valid, no lock, addresses 1/2/3/4, data 0xA1/0xB2/0xC3/0xD4.
  - Required: grants 0,1,2,3,0 on successive cycles; `reg_we` = 0x02,0x04,0x08,0x10 one cycle later; register 3 `q`=0xC3 two cycles after its grant.
- **Lock and burst limit (`MAX_BURST`=4):**
  - Stimulus: requester 2 valid with `req_lock`=1, requester 0 valid.
  - Required: 4 consecutive grants to 2, then grant to 0; `wr_count` advances by 5.
- **Stall:**
  - Stimulus: `stall`=1 for 3 cycles with requests pending.
  - Required: no `req_ready`, `reg_we`=0, `ptr` unchanged; first grant after `stall` drops goes to the same requester as before the stall.
- **Out-of-range and wrap:**
  - Stimulus: addr 9 with `NUM_REGS`=8.
  - Required: accepted, `reg_we`=0, `wr_count`+1.
  - Stimulus: preload `wr_count` to 0xFFFF, then accept one write.
  - Required: `wr_count`=0x0000.
- **Reset mid-operation:**
  - Stimulus: assert `rst` asynchronously right after an accept edge.
  - Required: `reg_we` clears immediately, the target register is unchanged, and `ptr` returns to 0.
